cmd_resp_uart_tx: RTL and testbench
===================================

Name: cmd_resp_uart_tx

Overview:
- Downstream neighbour of cmd_execute_tlb.
- Accepts response bytes on the cmd_resp_wr_data / cmd_resp_wr_en write port and buffers them in a small synchronous FIFO.
- Serializes each byte onto the UART TX line as an 8N1 frame, LSB first.
- Closes the loop back to the host: RX → byte FIFO → cmd_execute_tlb → this block → TX pin.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- BAUD, 115200, line rate. CLKS_PER_BIT = round(CLK_FREQ_HZ/BAUD), must be ≥ 2 (elaboration assertion).
- FIFO_DEPTH, 16, response buffer entries. Must be a power of 2, ≥ 2.
- DATA_W, 8, byte width. Fixed at 8; any other value is an elaboration error.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- cmd_resp_wr_data  in  DATA_W  response byte from cmd_execute_tlb.
- cmd_resp_wr_en  in  1  write strobe, one byte per asserted cycle.
- cmd_resp_full  out  1  FIFO full (count == FIFO_DEPTH), registered.
- resp_overflow  out  1  sticky flag: a write was dropped.
- overflow_clr  in  1  synchronous clear of resp_overflow.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current entry count.
- tx_busy  out  1  high when the FSM is not in IDLE.
- uart_tx  out  1  serial line, registered, idles high.

Behaviour:
- Reset (rst=0, asynchronous):
  - uart_tx=1; cmd_resp_full=0; resp_overflow=0; fifo_level=0; tx_busy=0.
  - FSM=IDLE; pointers, baud counter and bit counter = 0.
  - A frame in progress is abandoned. The line returns high immediately, with no stop bit.
- FIFO write:
  - Accepted iff cmd_resp_wr_en=1 and count < FIFO_DEPTH at the sampling edge.
  - A same-cycle pop does not make room for a write when full.
  - A write while full is dropped and sets resp_overflow on that edge.
  - If overflow_clr and a dropped write occur on the same edge, set wins.
- FIFO pop:
  - Only in the transitions marked "pop" below, and only if count > 0 before the edge.
  - A write into an empty FIFO is popped on the following edge, never the same edge.
- Simultaneous push and pop: count unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states (uart_tx is the registered value driven while in each state):
  - IDLE: uart_tx=1. If count > 0: pop head into shift register, bit counter=0, baud counter=0, go START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go DATA.
  - DATA: uart_tx=shift[0] for CLKS_PER_BIT cycles per bit. After each bit, shift right and increment bit counter. After bit 7, go STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. At the end: if count > 0, pop and go directly to START (no idle gap); else go IDLE.
- Timing:
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - Latency: uart_tx falls on the edge after the edge that wrote into an empty FIFO while IDLE.
  - The baud counter counts 0..CLKS_PER_BIT-1 and resets at every state or bit change.
- tx_busy = (state != IDLE), registered alongside the state.
- fifo_level and cmd_resp_full reflect post-edge count.

Decomposition:
- Package cmd_resp_pkg:
  - uart_tx_state_t enum {IDLE, START, DATA, STOP}.
  - Function clks_per_bit(clk_hz, baud) performing rounded division.
  - Constants UART_DATA_BITS=8 and UART_STOP_BITS=1.
- Sub-module resp_fifo:
  - Parameterised synchronous FIFO (DEPTH, W).
  - Ports: push, push_data, pop, head_data, count, full, empty, overflow pulse.
  - Same clk/rst style.
- The top holds the TX FSM and the sticky overflow register.

Test Plan (sim params: CLK_FREQ_HZ=1_000_000, BAUD=100_000, so CLKS_PER_BIT=10):
- Reset: hold rst=0 for 100 ns → uart_tx=1, fifo_level=0, tx_busy=0, cmd_resp_full=0, resp_overflow=0.
- Single byte: write 0xA5 → uart_tx low on the next edge for 10 cycles; data bits 1,0,1,0,0,1,0,1 at 10 cycles each; stop high 10 cycles; tx_busy high for exactly 100 cycles.
- Back-to-back: write 0x00, 0xFF, 0x3C on consecutive cycles → three frames in 300 contiguous cycles with no idle cycle between frames; monitor decodes 0x00, 0xFF, 0x3C.
- Fill/overflow: write 18 bytes 0x01..0x12 on consecutive cycles →
  - First byte is popped one edge after it is written.
  - cmd_resp_full asserts after the 17th write.
  - 18th write (0x12) is dropped and resp_overflow=1.
  - Monitor decodes 0x01..0x11 only.
  - Pulse overflow_clr → resp_overflow=0.
- Reset mid-frame: assert rst=0 during bit 3 of 0x5A → uart_tx=1 and fifo_level=0 immediately. After release, no further frames appear until the next write.
- Empty-race: write on the same edge the STOP state ends with the FIFO empty → FSM goes IDLE, pops on the next edge, START follows with exactly one IDLE cycle.

Source files
------------

// File: rtl/cmd_resp_pkg.sv
// Shared types, constants and helpers for the command-response UART transmitter.
package cmd_resp_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_STOP_BITS = 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// Synchronous FIFO with registered count/full/empty; writes while full are dropped.
module resp_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow_c
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("resp_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;

  // Room and occupancy are judged on the pre-edge count only.
  always_comb begin
    push_ok    = push && (count_q < CNT_W'(DEPTH));
    pop_ok     = pop && (count_q != '0);
    overflow_c = push && !push_ok;
    wr_ptr_d   = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop_ok);
    count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    full_d     = (count_d == CNT_W'(DEPTH));
    empty_d    = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;

endmodule

// File: rtl/cmd_resp_uart_tx.sv
// Buffers response bytes and serialises them as back-to-back 8N1 UART frames.
module cmd_resp_uart_tx
  import cmd_resp_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned DATA_W      = 8,
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] cmd_resp_wr_data,
  input  logic              cmd_resp_wr_en,
  output logic              cmd_resp_full,
  output logic              resp_overflow,
  input  logic              overflow_clr,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              tx_busy,
  output logic              uart_tx
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int unsigned STOP_CLKS    = UART_STOP_BITS * CLKS_PER_BIT;
  localparam int unsigned BAUD_W       = $clog2(STOP_CLKS);
  localparam int unsigned BIT_W        = $clog2(UART_DATA_BITS);

  if (DATA_W != UART_DATA_BITS) begin : g_bad_data_w
    $error("cmd_resp_uart_tx: DATA_W must be 8");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("cmd_resp_uart_tx: CLKS_PER_BIT must be at least 2");
  end

  logic [DATA_W-1:0] head_data;
  logic              fifo_empty;
  logic              fifo_ovf_c;
  logic              pop_c;

  resp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (cmd_resp_wr_en),
    .push_data  (cmd_resp_wr_data),
    .pop        (pop_c),
    .head_data  (head_data),
    .count      (fifo_level),
    .full       (cmd_resp_full),
    .empty      (fifo_empty),
    .overflow_c (fifo_ovf_c)
  );

  uart_tx_state_t    state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q;
  logic              ovf_q, ovf_d;
  logic              bit_end, stop_end;

  // Next state; uart_tx is computed for the state being entered so the pin is a flop.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    pop_c    = 1'b0;
    bit_end  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    stop_end = (baud_q == BAUD_W'(STOP_CLKS - 1));
    ovf_d    = fifo_ovf_c | (ovf_q & ~overflow_clr);

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          shift_d = head_data;
          bit_d   = '0;
          baud_d  = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == BIT_W'(UART_DATA_BITS - 1)) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + BIT_W'(1);
            tx_d    = shift_d[0];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (stop_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop_c   = 1'b1;
            shift_d = head_data;
            bit_d   = '0;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != IDLE);
      ovf_q   <= ovf_d;
    end
  end

  assign uart_tx       = tx_q;
  assign tx_busy       = busy_q;
  assign resp_overflow = ovf_q;

endmodule

// File: tb/tb_cmd_resp_uart_tx.sv
// Bench for cmd_resp_uart_tx: frame-level reference model, line decoder, directed and random traffic.
module tb_cmd_resp_uart_tx;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD_R = 100_000;
  localparam int          DEPTH  = 16;
  localparam int          C      = 10;
  localparam int          FRAME  = 10 * C;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       full, ovf, busy, tx;
  logic [4:0] level;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cmd_resp_uart_tx #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD        (BAUD_R),
    .FIFO_DEPTH  (DEPTH),
    .DATA_W      (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_resp_wr_data (wr_data),
    .cmd_resp_wr_en   (wr_en),
    .cmd_resp_full    (full),
    .resp_overflow    (ovf),
    .overflow_clr     (ovf_clr),
    .fifo_level       (level),
    .tx_busy          (busy),
    .uart_tx          (tx)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: byte queue plus position inside the current 100-cycle frame.
  int  mq[$];
  int  sent_q[$];
  int  fc = -1;
  int  cur = 0;
  bit  m_ovf = 1'b0;
  int  pre;
  bit  dropped;

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      sent_q.delete();
      fc    = -1;
      m_ovf = 1'b0;
    end else begin
      pre = mq.size();
      if (fc < 0 || fc == FRAME - 1) begin
        if (pre > 0) begin
          cur = mq.pop_front();
          sent_q.push_back(cur);
          fc = 0;
        end else begin
          fc = -1;
        end
      end else begin
        fc++;
      end
      dropped = wr_en && (pre >= DEPTH);
      if (wr_en && !dropped) mq.push_back(int'(wr_data));
      if (dropped) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
  end

  function automatic logic exp_line();
    int b;
    if (fc < 0) return 1'b1;
    b = fc / C;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur[b-1];
  endfunction

  always @(negedge clk) begin
    check_eq("uart_tx", 32'(tx), 32'(exp_line()));
    check_eq("tx_busy", 32'(busy), 32'(fc >= 0));
    check_eq("fifo_level", 32'(level), 32'(mq.size()));
    check_eq("cmd_resp_full", 32'(full), 32'(mq.size() == DEPTH));
    check_eq("resp_overflow", 32'(ovf), 32'(m_ovf));
  end

  // Line decoder: mid-bit sampling, independent of the model's timing.
  bit         dec_on = 1'b0;
  int         dec_cnt = 0;
  logic [7:0] dec_byte = 8'h00;
  logic [7:0] dec_log[$];

  always @(negedge clk) begin
    if (!rst) begin
      dec_on = 1'b0;
    end else if (!dec_on) begin
      if (tx === 1'b0) begin
        dec_on  = 1'b1;
        dec_cnt = 0;
      end
    end else begin
      dec_cnt++;
      if (dec_cnt >= 15 && dec_cnt <= 85 && (dec_cnt % C) == 5)
        dec_byte[3'((dec_cnt - 15) / C)] = tx;
      if (dec_cnt == 95) begin
        dec_on = 1'b0;
        dec_log.push_back(dec_byte);
        check_eq("dec_stop", 32'(tx), 32'(1));
        check_eq("dec_pending", 32'(sent_q.size() > 0), 32'(1));
        if (sent_q.size() > 0) check_eq("dec_byte", 32'(dec_byte), 32'(sent_q.pop_front()));
      end
    end
  end

  task automatic cyc(input logic en, input logic [7:0] d, input logic clr);
    @(negedge clk);
    wr_en   = en;
    wr_data = d;
    ovf_clr = clr;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((fc >= 0 || mq.size() != 0) && k < 2000) begin
      cyc(1'b0, 8'h00, 1'b0);
      k++;
    end
    check_eq("drain_done", 32'(fc >= 0 || mq.size() != 0), 32'(0));
    repeat (5) cyc(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n;
    int rises;
    logic prev;
    logic [7:0] b2b[3];
    int rates[3];
    b2b   = '{8'h00, 8'hFF, 8'h3C};
    rates = '{5, 35, 90};

    // Reset held for 10 cycles
    repeat (10) @(negedge clk);
    check_eq("rst_uart_tx", 32'(tx), 32'(1));
    check_eq("rst_level", 32'(level), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_full", 32'(full), 32'(0));
    check_eq("rst_ovf", 32'(ovf), 32'(0));
    #1 rst = 1'b1;

    // Single byte 0xA5
    cyc(1'b1, 8'hA5, 1'b0);
    busy_n = 0;
    for (int i = 1; i <= 130; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      if (busy) busy_n++;
      if (i == 1) check_eq("a5_line_before_start", 32'(tx), 32'(1));
      if (i == 2) check_eq("a5_start_bit", 32'(tx), 32'(0));
    end
    check_eq("a5_busy_cycles", 32'(busy_n), 32'(100));

    // Back-to-back frames
    dec_log.delete();
    busy_n = 0;
    rises  = 0;
    prev   = 1'b0;
    for (int i = 0; i < 333; i++) begin
      if (i < 3) cyc(1'b1, b2b[i], 1'b0);
      else cyc(1'b0, 8'h00, 1'b0);
      if (busy) busy_n++;
      if (busy && !prev) rises++;
      prev = busy;
    end
    check_eq("b2b_busy_cycles", 32'(busy_n), 32'(300));
    check_eq("b2b_busy_rises", 32'(rises), 32'(1));
    check_eq("b2b_dec_count", 32'(dec_log.size()), 32'(3));
    for (int i = 0; i < 3 && i < dec_log.size(); i++)
      check_eq("b2b_dec_value", 32'(dec_log[i]), 32'(b2b[i]));

    // Fill to full and overflow
    dec_log.delete();
    for (int i = 0; i < 18; i++) begin
      cyc(1'b1, 8'(i + 1), 1'b0);
      if (i == 1) check_eq("fill_first_write_level", 32'(level), 32'(1));
      if (i == 2) check_eq("fill_push_pop_level", 32'(level), 32'(1));
      if (i == 16) check_eq("fill_full_early", 32'(full), 32'(0));
      if (i == 17) begin
        check_eq("fill_full_after_17", 32'(full), 32'(1));
        check_eq("fill_ovf_not_yet", 32'(ovf), 32'(0));
      end
    end
    cyc(1'b0, 8'h00, 1'b0);
    check_eq("fill_ovf_set", 32'(ovf), 32'(1));
    check_eq("fill_level_16", 32'(level), 32'(16));
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    check_eq("fill_ovf_cleared", 32'(ovf), 32'(0));
    drain();
    check_eq("fill_dec_count", 32'(dec_log.size()), 32'(17));
    for (int i = 0; i < 17 && i < dec_log.size(); i++)
      check_eq("fill_dec_value", 32'(dec_log[i]), 32'(i + 1));

    // Reset during bit 3 of 0x5A, with a second byte queued
    dec_log.delete();
    cyc(1'b1, 8'h5A, 1'b0);
    cyc(1'b1, 8'h77, 1'b0);
    for (int i = 2; i <= 46; i++) cyc(1'b0, 8'h00, 1'b0);
    check_eq("midrst_busy_before", 32'(busy), 32'(1));
    check_eq("midrst_level_before", 32'(level), 32'(1));
    #1 rst = 1'b0;
    #1;
    check_eq("midrst_uart_tx", 32'(tx), 32'(1));
    check_eq("midrst_level", 32'(level), 32'(0));
    check_eq("midrst_busy", 32'(busy), 32'(0));
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    busy_n = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      if (busy || !tx) busy_n++;
    end
    check_eq("midrst_no_frames", 32'(busy_n), 32'(0));
    check_eq("midrst_no_decode", 32'(dec_log.size()), 32'(0));

    // Write lands on the edge where STOP ends with an empty FIFO
    cyc(1'b1, 8'hC3, 1'b0);
    for (int i = 1; i <= 100; i++) cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'h81, 1'b0);
    check_eq("race_in_stop_busy", 32'(busy), 32'(1));
    check_eq("race_in_stop_line", 32'(tx), 32'(1));
    cyc(1'b0, 8'h00, 1'b0);
    check_eq("race_idle_busy", 32'(busy), 32'(0));
    check_eq("race_idle_level", 32'(level), 32'(1));
    cyc(1'b0, 8'h00, 1'b0);
    check_eq("race_start_busy", 32'(busy), 32'(1));
    check_eq("race_start_line", 32'(tx), 32'(0));
    check_eq("race_start_level", 32'(level), 32'(0));
    drain();

    // Random traffic at increasing write density
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 1000; i++)
        cyc(1'b1 && ($urandom_range(0, 99) < rates[s]), 8'($urandom),
            $urandom_range(0, 49) == 0);
    end
    cyc(1'b0, 8'h00, 1'b0);
    drain();
    check_eq("all_frames_decoded", 32'(sent_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
